// File: rtl/accum_ctrl.sv
// accum_ctrl: frame accumulator. Collects qtty add/subtract beats into a
// b-bit wrapping accumulator, then presents the result until the consumer
// takes it. Tracks the carry of the last operation and a sticky signed
// overflow for the whole frame.
module accum_ctrl #(
  parameter int b    = 8,
  parameter int qtty = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [b-1:0] in_data,
  input  logic         in_add_n,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [b-1:0] out_sum,
  output logic         out_carry,
  output logic         out_ovf,
  output logic         busy
);

  localparam int CW = $clog2(qtty + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [b-1:0]    r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_carry;
  logic            r_ovf;

  logic            w_accept;
  logic            w_release;
  logic            w_last;
  logic [b-1:0]    w_opnd;
  logic [b:0]      w_sum;
  logic            w_ovf_now;

  // Subtract is add of the one's complement plus a carry-in of one.
  assign w_opnd    = in_data ^ {b{in_add_n}};
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_opnd} + {{b{1'b0}}, in_add_n};
  assign w_ovf_now = (w_opnd[b-1] == r_acc[b-1]) && (w_sum[b-1] != r_acc[b-1]);

  assign in_ready  = (r_state != DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_release = (r_state == DONE) && out_ready;
  // The beat being accepted now is the final one of the frame.
  assign w_last    = (r_cnt == CW'(qtty - 1));

  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_sum   = r_acc;
  assign out_carry = r_carry;
  assign out_ovf   = r_ovf;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: a frame ends on its last accepted beat and is held
  // in DONE until the consumer accepts it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = w_last ? DONE : ACC;
      ACC:  if (w_accept && w_last) w_state_nxt = DONE;
      DONE: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: accumulate on each accepted beat, clear when the result is
  // handed off. Accept and release never coincide since DONE blocks input.
  always_ff @(posedge clk) begin
    if (rst || w_release) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= w_sum[b-1:0];
      r_carry <= w_sum[b];
      r_ovf   <= r_ovf | w_ovf_now;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_accum_ctrl.sv
// Directed and randomized bench for accum_ctrl (b=8, qtty=5). A small
// reference model tracks the accumulator; completed-frame results are
// queued and compared when the block presents them.
module tb_accum_ctrl;

  localparam int B    = 8;
  localparam int QTTY = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [B-1:0] in_data;
  logic         in_add_n;
  logic         out_valid;
  logic         out_ready;
  logic [B-1:0] out_sum;
  logic         out_carry;
  logic         out_ovf;
  logic         busy;

  accum_ctrl #(.b(B), .qtty(QTTY)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_add_n(in_add_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carry(out_carry), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [B-1:0] sum;
    logic         carry;
    logic         ovf;
  } res_t;

  res_t sb[$];

  int checks = 0;
  int errors = 0;

  logic [B-1:0] m_acc;
  logic         m_carry;
  logic         m_ovf;
  int           m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; the DUT samples at the rising edge;
  // outputs are checked at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_clear();
    m_acc = '0; m_carry = 1'b0; m_ovf = 1'b0; m_cnt = 0;
  endtask

  task automatic model_beat(input logic [B-1:0] d, input logic sub);
    logic [B-1:0] op;
    logic [B:0]   s;
    op = sub ? ~d : d;
    s  = {1'b0, m_acc} + {1'b0, op} + (sub ? 9'd1 : 9'd0);
    if ((op[B-1] == m_acc[B-1]) && (s[B-1] != m_acc[B-1])) m_ovf = 1'b1;
    m_acc   = s[B-1:0];
    m_carry = s[B];
    m_cnt++;
    if (m_cnt == QTTY) sb.push_back('{sum: m_acc, carry: m_carry, ovf: m_ovf});
  endtask

  task automatic beat(input logic [B-1:0] d, input logic sub);
    in_valid = 1'b1; in_data = d; in_add_n = sub;
    chk("in_ready_pre_beat", in_ready, 1);
    step();
    in_valid = 1'b0;
    model_beat(d, sub);
    chk("beat_sum", out_sum, m_acc);
    chk("beat_carry", out_carry, m_carry);
    chk("beat_ovf", out_ovf, m_ovf);
    chk("beat_out_valid", out_valid, (m_cnt == QTTY));
    chk("beat_busy", busy, 1);
  endtask

  task automatic idle_cycle();
    out_ready = 1'($urandom_range(1));
    step();
    out_ready = 1'b0;
    chk("idle_sum_hold", out_sum, m_acc);
    chk("idle_no_valid", out_valid, 0);
    chk("idle_busy", busy, (m_cnt > 0));
  endtask

  // Wait (bounded) for a result, compare it with the queued expectation,
  // then release it and confirm the return to IDLE.
  task automatic take_result(input string tag);
    res_t exp;
    int   n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    chk({tag, "_valid_timeout"}, out_valid, 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      exp = sb.pop_front();
      chk({tag, "_sum"}, out_sum, exp.sum);
      chk({tag, "_carry"}, out_carry, exp.carry);
      chk({tag, "_ovf"}, out_ovf, exp.ovf);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    model_clear();
    chk({tag, "_rel_valid"}, out_valid, 0);
    chk({tag, "_rel_sum"}, out_sum, 0);
    chk({tag, "_rel_busy"}, busy, 0);
    chk({tag, "_rel_ready"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_add_n = 1'b0; out_ready = 1'b0;
    model_clear();
    step();
    step();
    chk("rst_sum", out_sum, 0);
    chk("rst_carry", out_carry, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step();
    chk("rst_in_ready", in_ready, 1);

    // Plain adds.
    for (int i = 1; i <= 5; i++) beat(8'(i), 1'b0);
    take_result("add15");

    // Subtracts of one: first has borrow (carry 0), later ones no borrow.
    for (int i = 0; i < 5; i++) beat(8'h01, 1'b1);
    take_result("sub5");

    // Signed overflow on the second beat stays sticky.
    beat(8'h7F, 1'b0);
    beat(8'h01, 1'b0);
    chk("ovf_set", out_ovf, 1);
    for (int i = 0; i < 3; i++) beat(8'h00, 1'b0);
    take_result("ovf");

    // Backpressure in DONE with input offered: nothing may move.
    for (int i = 0; i < 5; i++) beat(8'(8'h10 + i), 1'b0);
    in_valid = 1'b1; in_data = 8'h55; in_add_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", in_ready, 0);
      chk("bp_sum", out_sum, m_acc);
      chk("bp_carry", out_carry, m_carry);
      chk("bp_ovf", out_ovf, m_ovf);
    end
    in_valid = 1'b0;
    take_result("bp");

    // Reset mid-frame, with a beat offered on the reset edge.
    for (int i = 0; i < 3; i++) beat(8'h02, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h33;
    step();
    rst = 1'b0; in_valid = 1'b0;
    model_clear();
    chk("midrst_sum", out_sum, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) beat(8'h02, 1'b0);
    chk("midrst_0a", out_sum, 8'h0A);
    take_result("midrst");

    // Random gaps and mixed operations.
    for (int f = 0; f < 6; f++) begin
      while (m_cnt < QTTY) begin
        if ($urandom_range(1) == 1) beat(8'($urandom_range(255)), 1'($urandom_range(1)));
        else idle_cycle();
      end
      take_result("rand");
    end

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/accum_ctrl.md
ACCUM_CTRL -- requirements
Module: accum_ctrl

Interface
REQ-001 The parameter list SHALL be: b, default 8, operand and accumulator width in bits.
REQ-002 The parameter list SHALL also include: qtty, default 5, number of operands per frame; legal range qtty >= 1.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port in_valid  input  1  operand beat offered.
REQ-006 Port in_ready  output  1  block accepts an operand this cycle.
REQ-007 Port in_data  input  b  operand, two's complement.
REQ-008 Port in_add_n  input  1  operation select for the beat: 0 = add, 1 = subtract.
REQ-009 Port out_valid  output  1  frame result available.
REQ-010 Port out_ready  input  1  consumer takes the result.
REQ-011 Port out_sum  output  b  accumulator value.
REQ-012 Port out_carry  output  1  carry-out of the most recent accumulate operation.
REQ-013 Port out_ovf  output  1  sticky signed overflow for the current frame.
REQ-014 Port busy  output  1  a frame is in progress (state ACC or DONE).

Function
REQ-015 The block SHALL have three states: IDLE, ACC and DONE.
REQ-016 A beat SHALL be accepted when in_valid and in_ready are both high in the same cycle.
REQ-017 in_ready SHALL be 1 in IDLE and ACC, and 0 in DONE.
REQ-018 Each accepted beat SHALL update the accumulator as acc <= acc + (in_data XOR {b{in_add_n}}) + in_add_n, modulo 2^b.
REQ-019 Wrap-around SHALL be silent; the result SHALL never saturate.
REQ-020 out_carry SHALL register bit b of the (b+1)-bit sum for each accepted beat; for subtract, 1 means no borrow.
REQ-021 out_ovf SHALL be set when the operand-after-XOR and acc have equal sign bits and the result sign differs; it SHALL stay set until the frame is released.
REQ-022 IDLE: acc = 0, beat counter = 0, out_ovf = 0; the first accepted beat SHALL move the state to ACC, or directly to DONE if qtty = 1.
REQ-023 ACC: the beat counter (width clog2(qtty+1)) SHALL increment per accepted beat; acceptance of the qtty-th beat SHALL move the state to DONE.
REQ-024 Latency: out_valid SHALL rise in the cycle after the qtty-th beat is accepted, with out_sum, out_carry and out_ovf already final.
REQ-025 DONE: out_valid = 1, and all outputs SHALL hold stable until out_ready = 1.
REQ-026 On out_valid and out_ready both high, the next state SHALL be IDLE, with acc, counter, out_carry and out_ovf cleared.
REQ-027 The handoff cycle SHALL produce exactly one bubble: no beat can be accepted while in DONE.
REQ-028 Gaps in in_valid during ACC SHALL hold all state; no timeout is applied.
REQ-029 in_valid asserted in DONE SHALL be ignored, and no state SHALL change.
REQ-030 out_ready asserted outside DONE SHALL have no effect.
REQ-031 out_sum SHALL always show the current acc; it is meaningful only while out_valid = 1.

Reset
REQ-032 With rst high at a clock edge, the block SHALL go to IDLE on that edge.
REQ-033 Reset values SHALL be: acc = 0, counter = 0, out_sum = 0, out_carry = 0, out_ovf = 0, out_valid = 0, busy = 0, and in_ready = 1 in the cycle after rst deasserts.
REQ-034 rst SHALL take priority over any simultaneous handshake.
REQ-035 Reset mid-frame SHALL discard the partial frame; beats accepted on the rst edge SHALL be lost.

Verification (b=8, qtty=5)
REQ-036 Add 1,2,3,4,5 (in_add_n=0), back-to-back -> out_valid 1 cycle after 5th beat, out_sum=0x0F, out_carry=0, out_ovf=0.
REQ-037 Five subtracts of 0x01 -> intermediate 0xFF (carry 0), then 0xFE..0xFB (carry 1); final out_sum=0xFB, out_carry=1, out_ovf=0.
REQ-038 Add 0x7F, 0x01, 0x00, 0x00, 0x00 -> out_sum=0x80, out_ovf=1 (sticky through later beats), out_carry=0.
REQ-039 Backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 -> out_valid and outputs stable, in_ready=0, no beat accepted; out_ready=1 -> IDLE next cycle, out_sum=0.
REQ-040 Reset after 3 accepted beats, then a fresh 5-beat frame of 0x02 -> out_sum=0x0A; the partial frame SHALL NOT contribute.
REQ-041 Random in_valid gaps (50% duty) with mixed add/sub -> results SHALL match a modulo-256 reference model, and the counter SHALL never advance on an idle cycle.
